// File: rtl/click_decoder_pkg.sv
// Shared definitions for the button/click decoding blocks.
package click_decoder_pkg;

    localparam int CLICK_NUM_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } click_state_t;

endpackage

// File: rtl/click_window_timer.sv
// Inter-click window timer: counts CE ticks since clear, flags the tick that closes the window.
module click_window_timer #(
    parameter int WIN_WIDTH = 8,
    parameter int WIN_TICKS = 200
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic CE,
    output logic TC
);

    localparam logic [WIN_WIDTH-1:0] LAST = WIN_WIDTH'(WIN_TICKS - 1);

    logic [WIN_WIDTH-1:0] cnt;

    // Clear wins over CE, so a coincident press never expires the window.
    assign TC = CE && !CLR && (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (RST || CLR)
            cnt <= '0;
        else if (CE)
            cnt <= (cnt == LAST) ? '0 : cnt + WIN_WIDTH'(1);
    end

endmodule

// File: rtl/click_decoder.sv
// Groups debounced presses into multi-click sequences and reports the count once the window closes.
module click_decoder
    import click_decoder_pkg::*;
#(
    parameter int WIN_WIDTH  = 8,
    parameter int WIN_TICKS  = 200,
    parameter int MAX_CLICKS = 7
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CE,
    input  logic                   PRESS_IN,
    output logic                   CLICK_CEO,
    output logic [CLICK_NUM_W-1:0] CLICK_NUM,
    output logic                   BUSY
);

    localparam logic [CLICK_NUM_W-1:0] MAX_C = CLICK_NUM_W'(MAX_CLICKS);

    click_state_t           state;
    logic [CLICK_NUM_W-1:0] click_cnt;
    logic                   win_clr;
    logic                   win_tc;

    // Window only runs while collecting; any press restarts it.
    assign win_clr = (state != ST_COLLECT) || PRESS_IN;

    click_window_timer #(
        .WIN_WIDTH (WIN_WIDTH),
        .WIN_TICKS (WIN_TICKS)
    ) u_win (
        .CLK (CLK),
        .RST (RST),
        .CLR (win_clr),
        .CE  (CE),
        .TC  (win_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            click_cnt <= '0;
            CLICK_NUM <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PRESS_IN) begin
                        state     <= ST_COLLECT;
                        click_cnt <= CLICK_NUM_W'(1);
                    end
                end
                ST_COLLECT: begin
                    if (PRESS_IN) begin
                        if (click_cnt < MAX_C)
                            click_cnt <= click_cnt + CLICK_NUM_W'(1);
                    end else if (win_tc) begin
                        state     <= ST_REPORT;
                        CLICK_NUM <= click_cnt;
                    end
                end
                ST_REPORT: begin
                    if (PRESS_IN) begin
                        state     <= ST_COLLECT;
                        click_cnt <= CLICK_NUM_W'(1);
                    end else begin
                        state     <= ST_IDLE;
                        click_cnt <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    click_cnt <= '0;
                end
            endcase
        end
    end

    assign CLICK_CEO = (state == ST_REPORT);
    assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_click_decoder.sv
// Bench for click_decoder: directed vector table, corner sequences, random run against a tick-count model.
module tb_click_decoder;
    import click_decoder_pkg::*;

    localparam int WT = 4;
    localparam int MC = 7;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CE = 1'b0;
    logic       PRESS_IN = 1'b0;
    logic       CLICK_CEO;
    logic       BUSY;
    logic [2:0] CLICK_NUM;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: is a sequence open, how many clicks, how many quiet ticks.
    bit m_coll = 0;
    int m_n = 0;
    int m_quiet = 0;
    bit m_ceo = 0;
    int m_num = 0;

    int ceo_seen = 0;
    int last_num = 0;

    typedef struct {
        bit       rst;
        bit       press;
        bit       ce;
        bit       ceo;
        bit [2:0] num;
        bit       busy;
    } vec_t;

    vec_t tbl[10];

    click_decoder #(
        .WIN_WIDTH  (8),
        .WIN_TICKS  (WT),
        .MAX_CLICKS (MC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .PRESS_IN  (PRESS_IN),
        .CLICK_CEO (CLICK_CEO),
        .CLICK_NUM (CLICK_NUM),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit p, input bit c);
        RST = r;
        PRESS_IN = p;
        CE = c;
        @(posedge CLK);
        if (r) begin
            m_coll = 0; m_n = 0; m_quiet = 0; m_ceo = 0; m_num = 0;
        end else begin
            m_ceo = 0;
            if (p) begin
                m_n = m_coll ? ((m_n < MC) ? m_n + 1 : MC) : 1;
                m_coll = 1;
                m_quiet = 0;
            end else if (m_coll && c) begin
                m_quiet++;
                if (m_quiet == WT) begin
                    m_coll = 0;
                    m_ceo = 1;
                    m_num = m_n;
                    m_quiet = 0;
                end
            end
        end
        #1;
        if (CLICK_CEO) begin
            ceo_seen++;
            last_num = int'(CLICK_NUM);
        end
        RST = 0;
        PRESS_IN = 0;
        CE = 0;
    endtask

    task automatic mstep(input bit r, input bit p, input bit c, input string nm);
        step(r, p, c);
        chk({nm, ".ceo"}, int'(CLICK_CEO), int'(m_ceo));
        chk({nm, ".num"}, int'(CLICK_NUM), m_num);
        chk({nm, ".busy"}, int'(BUSY), int'(m_coll || m_ceo));
    endtask

    // One CE period at half rate: CE cycle then a quiet cycle.
    task automatic tick(input string nm);
        mstep(0, 0, 1, nm);
        mstep(0, 0, 0, nm);
    endtask

    initial begin
        // Single press, CE every 2nd CLK.
        tbl[0] = '{1, 0, 0, 0, 3'd0, 0};
        tbl[1] = '{0, 1, 0, 0, 3'd0, 1};
        tbl[2] = '{0, 0, 1, 0, 3'd0, 1};
        tbl[3] = '{0, 0, 0, 0, 3'd0, 1};
        tbl[4] = '{0, 0, 1, 0, 3'd0, 1};
        tbl[5] = '{0, 0, 0, 0, 3'd0, 1};
        tbl[6] = '{0, 0, 1, 0, 3'd0, 1};
        tbl[7] = '{0, 0, 0, 0, 3'd0, 1};
        tbl[8] = '{0, 0, 1, 1, 3'd1, 1};
        tbl[9] = '{0, 0, 0, 0, 3'd1, 0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].press, tbl[i].ce);
            chk($sformatf("vec%0d.ceo", i), int'(CLICK_CEO), int'(tbl[i].ceo));
            chk($sformatf("vec%0d.num", i), int'(CLICK_NUM), int'(tbl[i].num));
            chk($sformatf("vec%0d.busy", i), int'(BUSY), int'(tbl[i].busy));
        end

        // Three presses two CE apart.
        ceo_seen = 0;
        mstep(0, 1, 0, "tri");
        repeat (2) tick("tri");
        mstep(0, 1, 0, "tri");
        repeat (2) tick("tri");
        mstep(0, 1, 0, "tri");
        repeat (5) tick("tri");
        chk("tri.pulses", ceo_seen, 1);
        chk("tri.count", last_num, 3);

        // Nine presses one CE apart saturate at seven.
        ceo_seen = 0;
        repeat (9) begin
            mstep(0, 1, 0, "sat");
            tick("sat");
        end
        repeat (5) tick("sat");
        chk("sat.pulses", ceo_seen, 1);
        chk("sat.count", last_num, 7);

        // Press coincident with the window-closing CE.
        ceo_seen = 0;
        mstep(0, 1, 0, "coin");
        repeat (3) tick("coin");
        mstep(0, 1, 1, "coin");
        chk("coin.ceo", int'(CLICK_CEO), 0);
        chk("coin.busy", int'(BUSY), 1);
        repeat (5) tick("coin");
        chk("coin.pulses", ceo_seen, 1);
        chk("coin.count", last_num, 2);

        // Press landing in the report cycle.
        mstep(0, 1, 0, "rep");
        tick("rep");
        mstep(0, 1, 0, "rep");
        repeat (3) tick("rep");
        mstep(0, 0, 1, "rep");
        chk("rep.ceo_old", int'(CLICK_CEO), 1);
        chk("rep.num_old", int'(CLICK_NUM), 2);
        mstep(0, 1, 0, "rep");
        chk("rep.busy_kept", int'(BUSY), 1);
        ceo_seen = 0;
        repeat (5) tick("rep");
        chk("rep.pulses", ceo_seen, 1);
        chk("rep.count_new", last_num, 1);

        // Reset mid-collect, then press on the first free cycle.
        mstep(0, 1, 0, "rst");
        tick("rst");
        mstep(0, 1, 0, "rst");
        tick("rst");
        ceo_seen = 0;
        step(1, 1, 1);
        chk("rst.ceo", int'(CLICK_CEO), 0);
        chk("rst.num", int'(CLICK_NUM), 0);
        chk("rst.busy", int'(BUSY), 0);
        mstep(0, 1, 0, "rst");
        chk("rst.accept", int'(BUSY), 1);
        repeat (6) tick("rst");
        chk("rst.pulses", ceo_seen, 1);
        chk("rst.count", last_num, 1);

        // Random traffic with varying press density.
        for (int blk = 0; blk < 6; blk++) begin
            int rate;
            rate = 3 + blk * 3;
            repeat (500)
                mstep($urandom_range(0, 249) == 0, $urandom_range(0, rate) == 0,
                      $urandom_range(0, 1) == 1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/click_decoder.md
CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 Parameter WIN_WIDTH, 8, SHALL set the width of the inter-click window counter.
REQ-002 Parameter WIN_TICKS, 200, SHALL set the window length in CE ticks (1..2^WIN_WIDTH-1).
REQ-003 Parameter MAX_CLICKS, 7, SHALL set the click-count saturation value (1..7).
REQ-004 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-006 CE  in  1  SHALL be the time-base tick, one CLK cycle wide, shared with the upstream button filter.
REQ-007 PRESS_IN  in  1  SHALL be the one-cycle debounced-press pulse from the upstream button filter's BTN_CEO.
REQ-008 CLICK_CEO  out  1  SHALL pulse high for exactly one CLK cycle when a click sequence is complete.
REQ-009 CLICK_NUM  out  3  SHALL carry the number of clicks in the completed sequence.
REQ-010 BUSY  out  1  SHALL be high whenever a click sequence is being collected.

Function
REQ-011 States SHALL be IDLE, COLLECT, REPORT; reset state IDLE.
REQ-012 IDLE: PRESS_IN=1 -> COLLECT with click count=1 and window counter=0; otherwise stay.
REQ-013 COLLECT: PRESS_IN=1 -> click count=min(count+1, MAX_CLICKS), window counter=0, stay in COLLECT.
REQ-014 COLLECT: PRESS_IN=0 and CE=1 -> window counter increments by 1.
REQ-015 COLLECT: PRESS_IN=0, CE=1 and window counter=WIN_TICKS-1 -> REPORT on the next edge.
REQ-016 PRESS_IN and CE high in the same cycle: the press SHALL take precedence (counter cleared, not incremented, no expiry).
REQ-017 CE=0 and PRESS_IN=0 in COLLECT: no state change.
REQ-018 REPORT lasts exactly one CLK cycle; CLICK_CEO=1 in that cycle and CLICK_NUM=final count; next state IDLE.
REQ-019 PRESS_IN=1 during REPORT SHALL start a new sequence: next state COLLECT, count=1, counter=0; the current report is still issued.
REQ-020 Click count SHALL saturate at MAX_CLICKS; further presses only restart the window.
REQ-021 CLICK_NUM SHALL be registered and hold its last reported value until the next REPORT.
REQ-022 BUSY SHALL be 1 in COLLECT and REPORT, 0 in IDLE.
REQ-023 Latency: CLICK_CEO SHALL assert in the cycle after the CE edge that completes WIN_TICKS CE ticks without a press.
REQ-024 Window counter SHALL never wrap; it is bounded by WIN_TICKS-1.

Reset
REQ-025 RST=1 at a rising edge SHALL force IDLE, click count=0, window counter=0, CLICK_CEO=0, CLICK_NUM=0, BUSY=0.
REQ-026 RST SHALL take precedence over PRESS_IN and CE; a sequence interrupted by reset SHALL never be reported.
REQ-027 The first cycle after RST deasserts SHALL accept a PRESS_IN pulse normally.

Structure
REQ-028 State encoding (IDLE, COLLECT, REPORT) and the CLICK_NUM width constant SHALL live in the shared button package.
REQ-029 The window counter SHALL be a sub-module click_window_timer (clear, CE, terminal-count output), parameterised by WIN_WIDTH and WIN_TICKS.
REQ-030 All outputs SHALL be driven from registers or decoded state registers only, with no combinational path from inputs to outputs.

Verification (WIN_TICKS=4, MAX_CLICKS=7, CE every 2nd CLK)
REQ-031 Single press, then quiet -> one CLICK_CEO pulse, CLICK_NUM=1, 1 CLK after 4th CE; BUSY high from press+1 to pulse.
REQ-032 Three presses 2 CE apart, then quiet -> one pulse, CLICK_NUM=3; no pulse between presses.
REQ-033 Nine presses 1 CE apart -> one pulse, CLICK_NUM=7 (saturation).
REQ-034 PRESS_IN coincident with the 4th CE of a window -> no report; count increments; window restarts.
REQ-035 Press exactly in the REPORT cycle -> CLICK_CEO=1 with the old count, BUSY stays 1, the later report has CLICK_NUM=1.
REQ-036 RST asserted mid-COLLECT after 2 presses -> no CLICK_CEO, all outputs 0; a subsequent single press reports CLICK_NUM=1.
